dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the processor datapath (requester 0, CPU) and the program/data loader or debug port (requester 1, LDR).
- Sits between the datapath's data-memory address/write-data muxes and the Data_Memory instance.
- Grants one requester per cycle and drives the memory port from that requester.
- Raises cpu_stall so the PC and stack pointer hold while the CPU access waits.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- LOCK_MAX, 8, maximum consecutive loader grants under lock while the CPU is requesting; range 1..255.
- WAIT_W, 16, width of the saturating CPU wait-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (rst=0 resets on the clk edge)
- cpu_req  in  1  CPU memory access request (MemRead | MemWrite)
- cpu_we  in  1  CPU write enable
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  read data to CPU
- cpu_stall  out  1  CPU request pending, not granted this cycle
- ldr_req  in  1  loader request
- ldr_we  in  1  loader write enable
- ldr_lock  in  1  loader asks to keep ownership for the following cycles
- ldr_addr  in  AW  loader address
- ldr_wdata  in  DW  loader write data
- ldr_rdata  out  DW  read data to loader
- ldr_gnt  out  1  loader granted this cycle
- mem_we  out  1  to Data_Memory WE
- mem_re  out  1  to Data_Memory RE
- mem_addr  out  AW  to Data_Memory A
- mem_wdata  out  DW  to Data_Memory WD
- mem_rdata  in  DW  from Data_Memory RD (combinational read)
- cpu_wait_cnt  out  WAIT_W  saturating count of stalled CPU cycles

Behaviour:
- Grant timing:
  - Grant is combinational within the cycle, from the requests, the FSM state and last_gnt.
  - The memory access occurs in the granted cycle: zero added latency.
  - Read data: cpu_rdata = mem_rdata when the CPU is granted, else 0; ldr_rdata likewise for the loader.
  - Requesters hold their request fields stable until granted.
- Memory port:
  - Granted requester drives mem_addr and mem_wdata.
  - mem_we = granted requester's we; mem_re = granted & ~we.
  - No grant: mem_we = mem_re = 0, mem_addr = 0, mem_wdata = 0.
- FSM states:
  - IDLE/RR: no ownership held.
    - Single requester: that requester is granted.
    - Both requesting: the one not equal to last_gnt wins (round-robin).
    - Granted loader with ldr_lock=1: next state LOCK.
  - LOCK: the loader owns the port.
    - Loader is granted whenever ldr_req=1.
    - Each cycle in which the loader is granted while cpu_req=1 increments lock_cnt.
    - lock_cnt reaching LOCK_MAX: next state FORCE.
    - ldr_lock=0 or ldr_req=0: next state RR; lock_cnt clears.
    - CPU requests alone in LOCK (ldr_req=0): the CPU is granted and the state returns to RR.
  - FORCE: the CPU is granted for exactly one cycle if cpu_req=1; lock_cnt clears.
    - Next state LOCK if ldr_lock is still 1, else RR.
    - cpu_req=0 in FORCE: the loader is granted if requesting.
- last_gnt updates on every granted cycle.
- cpu_stall = cpu_req & ~cpu_granted, combinational.
- cpu_wait_cnt increments on each stalled cycle and saturates at all-ones.
- Reset (rst=0 at the edge):
  - State RR, last_gnt = LDR (so the CPU wins the first conflict), lock_cnt = 0, cpu_wait_cnt = 0.
  - Outputs after reset: ldr_gnt=0, cpu_stall=cpu_req, mem_* = 0 until a request is seen.
  - Reset mid-lock drops ownership immediately.
- Simultaneous ldr_lock deassert and lock_cnt reaching LOCK_MAX: RR takes precedence over FORCE.
- A write and a read never share a cycle: there is a single port.

Decomposition:
- Shared package dmem_arb_pkg:
  - State encoding: ST_RR=2'd0, ST_LOCK=2'd1, ST_FORCE=2'd2.
  - Requester IDs: REQ_CPU=1'b0, REQ_LDR=1'b1.
- One natural sub-module: dmem_arb_fsm, containing the state, last_gnt and lock_cnt registers and the grant decode.
- Muxing and counters stay in the top.

Test Plan:
- Reset, then cpu_req=1 with cpu_we=0, addr=0x10, mem_rdata=0xDEADBEEF, ldr idle -> same cycle: mem_re=1, cpu_rdata=0xDEADBEEF, cpu_stall=0.
- Both request every cycle, no lock -> grants alternate CPU, LDR, CPU, LDR; cpu_stall=1 on LDR cycles; cpu_wait_cnt=2 after 4 cycles.
- ldr_lock=1 and both requesting continuously, LOCK_MAX=8 -> 8 loader grants, then 1 CPU grant, then 8 loader grants.
- Loader write 0x1234 to 0x40 while the CPU is idle, then the CPU reads 0x40 -> mem_we=1 with the loader's addr/data; the later CPU read returns 0x1234.
- rst=0 asserted in LOCK after 3 loader grants -> next cycle state RR, lock_cnt=0, cpu_wait_cnt=0; with both requesting, the CPU wins the first conflict.
- ldr_lock drops in the cycle lock_cnt reaches LOCK_MAX -> next state RR, not FORCE; round-robin resumes.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and requester IDs.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_RR    = 2'd0,
    ST_LOCK  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/dmem_arb_fsm.sv
// Grant decode for the CPU/loader data-memory arbiter: round-robin, loader lock
// with a bounded burst length, and a one-cycle forced CPU slot.
module dmem_arb_fsm
  import dmem_arb_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic ldr_lock,
  output logic cpu_gnt,
  output logic ldr_gnt
);

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  arb_state_t state_reg, state_next;
  logic       last_gnt_reg, last_gnt_next;
  logic [7:0] lock_cnt_reg, lock_cnt_next;
  logic [7:0] cnt_inc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_RR;
      last_gnt_reg <= REQ_LDR;
      lock_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      last_gnt_reg <= last_gnt_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end

  always_comb begin
    cpu_gnt       = 1'b0;
    ldr_gnt       = 1'b0;
    state_next    = state_reg;
    last_gnt_next = last_gnt_reg;
    lock_cnt_next = lock_cnt_reg;
    cnt_inc       = lock_cnt_reg + 8'd1;

    case (state_reg)
      ST_RR: begin
        if (cpu_req && ldr_req) begin
          cpu_gnt = (last_gnt_reg == REQ_LDR);
          ldr_gnt = (last_gnt_reg == REQ_CPU);
        end else begin
          cpu_gnt = cpu_req;
          ldr_gnt = ldr_req;
        end
        lock_cnt_next = 8'd0;
        // The grant that opens a lock already counts toward the burst.
        if (ldr_gnt && ldr_lock) begin
          lock_cnt_next = cpu_req ? cnt_inc : 8'd0;
          state_next    = (cpu_req && cnt_inc == LOCK_MAX_C) ? ST_FORCE : ST_LOCK;
        end
      end
      ST_LOCK: begin
        ldr_gnt = ldr_req;
        cpu_gnt = cpu_req & ~ldr_req;
        // Releasing the lock wins over hitting the burst limit.
        if (!ldr_req || !ldr_lock) begin
          state_next    = ST_RR;
          lock_cnt_next = 8'd0;
        end else if (cpu_req) begin
          lock_cnt_next = cnt_inc;
          if (cnt_inc == LOCK_MAX_C) state_next = ST_FORCE;
        end
      end
      ST_FORCE: begin
        cpu_gnt       = cpu_req;
        ldr_gnt       = ~cpu_req & ldr_req;
        lock_cnt_next = 8'd0;
        state_next    = ldr_lock ? ST_LOCK : ST_RR;
      end
      default: begin
        state_next    = ST_RR;
        lock_cnt_next = 8'd0;
      end
    endcase

    if (cpu_gnt)      last_gnt_next = REQ_CPU;
    else if (ldr_gnt) last_gnt_next = REQ_LDR;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU datapath and the loader/debug
// port; grants are same-cycle, and a stalled CPU is counted in cpu_wait_cnt.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8,
  parameter int WAIT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic              ldr_lock,
  input  logic [AW-1:0]     ldr_addr,
  input  logic [DW-1:0]     ldr_wdata,
  output logic [DW-1:0]     ldr_rdata,
  output logic              ldr_gnt,
  output logic              mem_we,
  output logic              mem_re,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic [WAIT_W-1:0] cpu_wait_cnt
);

  logic              cpu_gnt;
  logic [WAIT_W-1:0] wait_cnt_reg;

  dmem_arb_fsm #(
    .LOCK_MAX(LOCK_MAX)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_req),
    .ldr_req (ldr_req),
    .ldr_lock(ldr_lock),
    .cpu_gnt (cpu_gnt),
    .ldr_gnt (ldr_gnt)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_re    = ~cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ldr_gnt) begin
      mem_we    = ldr_we;
      mem_re    = ~ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
  end

  assign cpu_rdata = cpu_gnt ? mem_rdata : '0;
  assign ldr_rdata = ldr_gnt ? mem_rdata : '0;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
    end else if (cpu_stall && !(&wait_cnt_reg)) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  assign cpu_wait_cnt = wait_cnt_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, same-cycle reads, round-robin, lock bursts,
// reset mid-lock, lock release at the burst limit, and loader write / CPU read-back.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, ldr_gnt, mem_we, mem_re;
  logic [15:0] cpu_wait_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Tiny memory model: remembers the last write; 0x10 holds 0xDEADBEEF; elsewhere ~addr.
  logic        wr_valid = 1'b0;
  logic [31:0] wr_addr  = 32'h0;
  logic [31:0] wr_data  = 32'h0;

  always_comb begin
    if (wr_valid && mem_addr == wr_addr) mem_rdata = wr_data;
    else if (mem_addr == 32'h10)         mem_rdata = 32'hDEADBEEF;
    else                                 mem_rdata = ~mem_addr;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      wr_valid <= 1'b1;
      wr_addr  <= mem_addr;
      wr_data  <= mem_wdata;
    end
  end

  always #5 clk = ~clk;

  dmem_arbiter #(
    .AW(32), .DW(32), .LOCK_MAX(8), .WAIT_W(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .ldr_req     (ldr_req),
    .ldr_we      (ldr_we),
    .ldr_lock    (ldr_lock),
    .ldr_addr    (ldr_addr),
    .ldr_wdata   (ldr_wdata),
    .ldr_rdata   (ldr_rdata),
    .ldr_gnt     (ldr_gnt),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .cpu_wait_cnt(cpu_wait_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+1; combinational checks happen at posedge+3.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; ldr_req = 1'b0; ldr_we = 1'b0; ldr_lock = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_lock = 1'b0; ldr_addr = 32'h0; ldr_wdata = 32'h0;
    tick();
    tick();
    rst = 1'b1;

    // Reset state
    settle();
    chk("rst_ldr_gnt", 64'(ldr_gnt), 64'd0);
    chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_re", 64'(mem_re), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_wait_cnt", 64'(cpu_wait_cnt), 64'd0);
    chk("rst_state", 64'(dut.u_fsm.state_reg), 64'(ST_RR));
    tick();

    // CPU read alone: same-cycle access
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    settle();
    chk("rd_mem_re", 64'(mem_re), 64'd1);
    chk("rd_mem_addr", 64'(mem_addr), 64'h10);
    chk("rd_cpu_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
    chk("rd_cpu_stall", 64'(cpu_stall), 64'd0);
    chk("rd_ldr_rdata", 64'(ldr_rdata), 64'd0);
    tick();

    // Round-robin without lock: CPU, LDR, CPU, LDR
    do_reset();
    cpu_req = 1'b1; cpu_addr = 32'h20; ldr_req = 1'b1; ldr_addr = 32'h30;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_ldr_gnt", 64'(ldr_gnt), (i % 2 == 0) ? 64'd0 : 64'd1);
      chk("rr_cpu_stall", 64'(cpu_stall), (i % 2 == 0) ? 64'd0 : 64'd1);
      chk("rr_mem_addr", 64'(mem_addr), (i % 2 == 0) ? 64'h20 : 64'h30);
      chk("rr_cpu_rdata", 64'(cpu_rdata), (i % 2 == 0) ? 64'hFFFFFFDF : 64'd0);
      chk("rr_ldr_rdata", 64'(ldr_rdata), (i % 2 == 0) ? 64'd0 : 64'hFFFFFFCF);
      tick();
    end
    chk("rr_wait_cnt", 64'(cpu_wait_cnt), 64'd2);

    // Lock with both requesting: CPU, 8x LDR, CPU, 8x LDR, CPU
    do_reset();
    cpu_req = 1'b1; ldr_req = 1'b1; ldr_lock = 1'b1;
    for (int i = 0; i < 19; i++) begin
      settle();
      chk("lock_ldr_gnt", 64'(ldr_gnt), (i % 9 == 0) ? 64'd0 : 64'd1);
      chk("lock_cpu_stall", 64'(cpu_stall), (i % 9 == 0) ? 64'd0 : 64'd1);
      tick();
    end
    chk("lock_wait_cnt", 64'(cpu_wait_cnt), 64'd16);

    // Reset while in LOCK after 3 loader grants
    do_reset();
    cpu_req = 1'b1; ldr_req = 1'b1; ldr_lock = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_state_lock", 64'(dut.u_fsm.state_reg), 64'(ST_LOCK));
    chk("mid_lock_cnt3", 64'(dut.u_fsm.lock_cnt_reg), 64'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_state_rr", 64'(dut.u_fsm.state_reg), 64'(ST_RR));
    chk("mid_lock_cnt0", 64'(dut.u_fsm.lock_cnt_reg), 64'd0);
    chk("mid_wait_cnt0", 64'(cpu_wait_cnt), 64'd0);
    settle();
    chk("mid_cpu_first", 64'(cpu_stall), 64'd0);
    chk("mid_ldr_gnt", 64'(ldr_gnt), 64'd0);
    tick();

    // Lock released in the cycle the burst limit is reached: back to RR, not FORCE
    do_reset();
    cpu_req = 1'b1; ldr_req = 1'b1; ldr_lock = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("drop_lock_cnt7", 64'(dut.u_fsm.lock_cnt_reg), 64'd7);
    ldr_lock = 1'b0;
    settle();
    chk("drop_ldr_gnt", 64'(ldr_gnt), 64'd1);
    tick();
    chk("drop_state_rr", 64'(dut.u_fsm.state_reg), 64'(ST_RR));
    settle();
    chk("drop_rr_cpu", 64'(cpu_stall), 64'd0);
    tick();
    settle();
    chk("drop_rr_ldr", 64'(ldr_gnt), 64'd1);
    tick();

    // Loader write while CPU idle, then CPU reads it back
    cpu_req = 1'b0; ldr_req = 1'b1; ldr_we = 1'b1; ldr_lock = 1'b0;
    ldr_addr = 32'h40; ldr_wdata = 32'h1234;
    settle();
    chk("wr_ldr_gnt", 64'(ldr_gnt), 64'd1);
    chk("wr_mem_we", 64'(mem_we), 64'd1);
    chk("wr_mem_re", 64'(mem_re), 64'd0);
    chk("wr_mem_addr", 64'(mem_addr), 64'h40);
    chk("wr_mem_wdata", 64'(mem_wdata), 64'h1234);
    tick();
    ldr_req = 1'b0; ldr_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    settle();
    chk("rb_mem_re", 64'(mem_re), 64'd1);
    chk("rb_mem_we", 64'(mem_we), 64'd0);
    chk("rb_cpu_rdata", 64'(cpu_rdata), 64'h1234);
    tick();
    cpu_req = 1'b0;
    settle();
    chk("idle_mem_addr", 64'(mem_addr), 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
